ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Round-robin arbiter that shares one RAM access port between the instruction-fetch master and the data master of the memory commutator. It sits between the two core-side stb/ack request ports and a single stb/ack port of `RAM`. It holds each grant until the RAM acknowledges, and it terminates stalled transfers with an error pulse from a per-grant watchdog.

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 15, max grant cycles without `ram_ack_i` before abort; 0 disables the watchdog

Ports:
- `sys_clk`  in  1  single clock, rising edge
- `sys_rst_n`  in  1  reset, asynchronous, active-low
- `i_stb_i` / `d_stb_i`  in  1  instruction / data request strobe
- `i_we_i` / `d_we_i`  in  1  write enable
- `i_addr_i` / `d_addr_i`  in  ADDR_W  address
- `i_data_i` / `d_data_i`  in  DATA_W  write data
- `i_ack_o` / `d_ack_o`  out  1  transfer complete
- `i_err_o` / `d_err_o`  out  1  transfer aborted by the watchdog
- `i_data_o` / `d_data_o`  out  DATA_W  read data
- `ram_stb_o`  out  1  RAM strobe
- `ram_we_o`  out  1  RAM write enable
- `ram_addr_o`  out  ADDR_W  RAM address
- `ram_data_o`  out  DATA_W  RAM write data
- `ram_ack_i`  in  1  RAM acknowledge
- `ram_data_i`  in  DATA_W  RAM read data

## Operation
- **Master protocol:** classic handshake. A master raises stb with we/addr/data and holds all of them stable until it sees ack or err.
- **States:** IDLE, GNT_I, GNT_D. A registered 1-bit `last` records the most recently served master; it resets to I, so D wins the first contention.
- **IDLE:**
  - only `i_stb_i` → GNT_I; only `d_stb_i` → GNT_D.
  - both → grant the master that is not `last`.
  - neither → stay in IDLE.
- **GNT_x, `ram_ack_i`=1:**
  - pulse `x_ack_o` and update `last`=x.
  - next state: GNT of the other master if its stb is high, else IDLE.
  - back-to-back grants have no idle cycle.
- **GNT_x, watchdog expiry** (counter == TIMEOUT, no ack): pulse `x_err_o`. Next state and the `last` update are the same as for an ack.
- **Ack and expiry in the same cycle:** ack wins and err stays low.
- **RAM outputs:**
  - in GNT_x: `ram_stb_o`=1; `ram_we_o`/`ram_addr_o`/`ram_data_o` are a combinational mux from master x.
  - in IDLE: all four are 0.
- **Acks:** `x_ack_o` = `ram_ack_i` & (state==GNT_x), combinational. `ram_ack_i` is ignored in IDLE.
- **Read data:** `x_data_o` = `ram_data_i` while in GNT_x, else 0.
- **Watchdog counter:**
  - width $clog2(TIMEOUT+1).
  - cleared on entry to any GNT state and on every state change; increments each GNT cycle without ack; saturates.
- **Stb held after ack:** a master whose stb stays high after its ack is treated as a new request and arbitrated normally.
- **Stb dropped mid-grant:** illegal; the grant is held regardless.
- **Reset:** asserting `sys_rst_n` mid-grant forces IDLE immediately, with no ack or err issued.

## Timing
- **Reset values:** state IDLE, `last`=I, counter 0. All outputs are 0: `ram_stb_o`, `ram_we_o`, `ram_addr_o`, `ram_data_o`, both acks, both errs, both `data_o`.
- **Grant latency:** stb sampled at edge N, `ram_stb_o` high from edge N+1.
- **Ack path:** no added latency on ack or read data (same-cycle pass-through).
- **Minimum transfer:** 2 cycles from stb to ack when the RAM acks combinationally.
- **Abort timing:** err asserts in the cycle where the counter equals TIMEOUT, i.e. TIMEOUT+1 cycles after grant. `ram_stb_o` drops at the next edge.
- **Pulse width:** ack and err are high for exactly one cycle per transfer.

## Structure
- **Package `ram_arb_pkg`:**
  - state enum `arb_state_t` {IDLE, GNT_I, GNT_D}
  - master-id constants `MST_I`=0, `MST_D`=1
  - default widths
- **Sub-module `ram_arb_watchdog`:** saturating counter with `clr`, `en` and `expired` outputs; TIMEOUT=0 ties `expired` to 0.
- **Top level:** the FSM, the `last` register and the muxes.

## Test plan
- **Single read:** D only reads addr 16'h20 after I wrote 32'hAAAA there → `ram_stb_o` high 1 cycle after `d_stb_i`; `d_ack_o` in the same cycle as `ram_ack_i`; `d_data_o`=32'hAAAA; `i_ack_o` stays 0.
- **Contention from reset:** I and D both raise stb in the same cycle → D served first, then I with no idle cycle between. Drive a 16'h20 write on D and 16'h24 on I: `ram_addr_o` sequence 16'h20, 16'h24.
- **Sustained fairness:** both held continuously for 6 transfers → grants alternate D,I,D,I,D,I; each ack is a 1-cycle pulse.
- **Watchdog:** TIMEOUT=3, RAM never acks → `d_err_o` pulses 4 cycles after grant; `ram_stb_o` low the next cycle. A pending I request is then granted. With TIMEOUT=0, stb is held indefinitely.
- **Ack beats expiry:** `ram_ack_i` in the expiry cycle → ack=1, err=0.
- **Reset mid-grant:** `sys_rst_n` pulled low while in GNT_I with ack pending → all outputs 0 immediately. After release, a simultaneous request resolves to D first.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the RAM port arbiter
//
// Purpose: arbiter state encoding, master identifiers and default widths.
// Ports:   none (package).
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/ram_arb_watchdog.sv
// rtl/ram_arb_watchdog.sv - saturating per-grant watchdog counter
//
// Purpose: counts grant cycles without an acknowledge and flags expiry.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         restart the count from zero (takes priority over en)
//   en          count this cycle
//   expired     count has reached TIMEOUT; constant 0 when TIMEOUT is 0
module ram_arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clr, en};
      assign expired       = 1'b0;
    end else begin : g_on
      localparam int            CW    = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired = (cnt_q == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one RAM port between I and D masters
//
// Purpose: grants the RAM port to the instruction or data master, holds the
//          grant until the RAM acks or the watchdog expires, alternates under
//          contention.
// Ports:
//   sys_clk, sys_rst_n            clock, asynchronous active-low reset
//   i_* / d_*                     core-side stb/we/addr/data requests, ack/err/data responses
//   ram_stb_o/we_o/addr_o/data_o  RAM request (all zero while idle)
//   ram_ack_i, ram_data_i         RAM response, passed straight through to the granted master
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i_stb_i,
  input  logic              i_we_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic              i_ack_o,
  output logic              i_err_o,
  output logic [DATA_W-1:0] i_data_o,
  input  logic              d_stb_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic              d_ack_o,
  output logic              d_err_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              ram_stb_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic              ram_ack_i,
  input  logic [DATA_W-1:0] ram_data_i
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       wd_expired;

  // Any state change restarts the watchdog, so each grant starts from zero
  // even on back-to-back grants.
  ram_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clr     (state_d != state_q),
    .en      ((state_q != IDLE) && !ram_ack_i),
    .expired (wd_expired)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      last_q  <= MST_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (i_stb_i && d_stb_i) begin
          state_d = (last_q == MST_I) ? GNT_D : GNT_I;
        end else if (i_stb_i) begin
          state_d = GNT_I;
        end else if (d_stb_i) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        if (ram_ack_i || wd_expired) begin
          last_d  = MST_I;
          state_d = d_stb_i ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        if (ram_ack_i || wd_expired) begin
          last_d  = MST_D;
          state_d = i_stb_i ? GNT_I : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ack wins over a simultaneous expiry, hence err is masked by ram_ack_i.
  always_comb begin
    ram_stb_o  = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    i_ack_o    = 1'b0;
    i_err_o    = 1'b0;
    i_data_o   = '0;
    d_ack_o    = 1'b0;
    d_err_o    = 1'b0;
    d_data_o   = '0;
    case (state_q)
      GNT_I: begin
        ram_stb_o  = 1'b1;
        ram_we_o   = i_we_i;
        ram_addr_o = i_addr_i;
        ram_data_o = i_data_i;
        i_ack_o    = ram_ack_i;
        i_err_o    = wd_expired && !ram_ack_i;
        i_data_o   = ram_data_i;
      end
      GNT_D: begin
        ram_stb_o  = 1'b1;
        ram_we_o   = d_we_i;
        ram_addr_o = d_addr_i;
        ram_data_o = d_data_i;
        d_ack_o    = ram_ack_i;
        d_err_o    = wd_expired && !ram_ack_i;
        d_data_o   = ram_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed and randomized bench for ram_port_arbiter
module tb_ram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NONE = 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          i_stb_i = 1'b0, i_we_i = 1'b0, d_stb_i = 1'b0, d_we_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0, d_addr_i = '0;
  logic [DW-1:0] i_data_i = '0, d_data_i = '0, ram_data_i = '0;
  logic          ram_ack_i = 1'b0;

  logic          i_ack_o, i_err_o, d_ack_o, d_err_o, ram_stb_o, ram_we_o;
  logic [DW-1:0] i_data_o, d_data_o, ram_data_o;
  logic [AW-1:0] ram_addr_o;

  logic          z_i_ack_o, z_i_err_o, z_d_ack_o, z_d_err_o, z_ram_stb_o, z_ram_we_o;
  logic [DW-1:0] z_i_data_o, z_d_data_o, z_ram_data_o;
  logic [AW-1:0] z_ram_addr_o;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(3)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .i_stb_i(i_stb_i), .i_we_i(i_we_i), .i_addr_i(i_addr_i), .i_data_i(i_data_i),
    .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_data_o(i_data_o),
    .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
    .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_data_o(d_data_o),
    .ram_stb_o(ram_stb_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_ack_i(ram_ack_i), .ram_data_i(ram_data_i)
  );

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .i_stb_i(i_stb_i), .i_we_i(i_we_i), .i_addr_i(i_addr_i), .i_data_i(i_data_i),
    .i_ack_o(z_i_ack_o), .i_err_o(z_i_err_o), .i_data_o(z_i_data_o),
    .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
    .d_ack_o(z_d_ack_o), .d_err_o(z_d_err_o), .d_data_o(z_d_data_o),
    .ram_stb_o(z_ram_stb_o), .ram_we_o(z_ram_we_o), .ram_addr_o(z_ram_addr_o),
    .ram_data_o(z_ram_data_o), .ram_ack_i(ram_ack_i), .ram_data_i(ram_data_i)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int failed = 0;

  // Reference model: owner of the port (0=I, 1=D, NONE), last served master,
  // grant-cycle count, outstanding requests per master and a RAM image.
  int            cur = NONE, last_m = 0, cnt = 0;
  bit            done = 1'b0;
  bit            pend [2];
  bit            mwe  [2];
  logic [AW-1:0] maddr[2];
  logic [DW-1:0] mdat [2];
  logic [DW-1:0] mem  [0:255];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_m(input int m);
    if (m == 0) begin
      i_stb_i = pend[0]; i_we_i = mwe[0]; i_addr_i = maddr[0]; i_data_i = mdat[0];
    end else begin
      d_stb_i = pend[1]; d_we_i = mwe[1]; d_addr_i = maddr[1]; d_data_i = mdat[1];
    end
  endtask

  task automatic req(input int m, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[m] = 1'b1; mwe[m] = we; maddr[m] = a; mdat[m] = d;
    drive_m(m);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stb"}, ram_stb_o, 0);
    chk({tag, "_we"}, ram_we_o, 0);
    chk({tag, "_addr"}, ram_addr_o, 0);
    chk({tag, "_wdata"}, ram_data_o, 0);
    chk({tag, "_acks"}, {i_ack_o, d_ack_o}, 0);
    chk({tag, "_errs"}, {i_err_o, d_err_o}, 0);
    chk({tag, "_idata"}, i_data_o, 0);
    chk({tag, "_ddata"}, d_data_o, 0);
    chk({tag, "_z_stb"}, z_ram_stb_o, 0);
  endtask

  task automatic do_reset(input string tag);
    sys_rst_n = 1'b0;
    ram_ack_i = 1'b0; ram_data_i = '0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; mwe[m] = 1'b0; maddr[m] = '0; mdat[m] = '0;
      drive_m(m);
    end
    cur = NONE; last_m = 0; cnt = 0; done = 1'b0;
    #1;
    chk_zero(tag);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // One cycle of observation: request side, then RAM response and master side.
  task automatic step(input bit ack);
    bit            act = (cur != NONE);
    int            g = act ? cur : 0;
    bit            er;
    logic [DW-1:0] rd;
    chk("ram_stb", ram_stb_o, act);
    chk("ram_we", ram_we_o, act ? mwe[g] : 1'b0);
    chk("ram_addr", ram_addr_o, act ? maddr[g] : '0);
    chk("ram_wdata", ram_data_o, act ? mdat[g] : '0);
    rd = act ? mem[maddr[g][7:0]] : $urandom;
    ram_ack_i = ack;
    ram_data_i = rd;
    #1;
    er = act && !ack && (cnt == 3);
    chk("i_ack", i_ack_o, ack && cur == 0);
    chk("d_ack", d_ack_o, ack && cur == 1);
    chk("i_err", i_err_o, er && cur == 0);
    chk("d_err", d_err_o, er && cur == 1);
    chk("i_data", i_data_o, (cur == 0) ? rd : '0);
    chk("d_data", d_data_o, (cur == 1) ? rd : '0);
    done = act && (ack || er);
    if (done) begin
      last_m = cur;
      if (ack && mwe[cur]) mem[maddr[cur][7:0]] = mdat[cur];
      pend[cur] = 1'b0;
      drive_m(cur);
    end
  endtask

  task automatic adv();
    int prev = cur;
    if (cur != NONE) begin
      if (done) cur = pend[1 - cur] ? 1 - cur : NONE;
    end else if (pend[0] && pend[1]) begin
      cur = 1 - last_m;
    end else if (pend[0]) begin
      cur = 0;
    end else if (pend[1]) begin
      cur = 1;
    end
    if (cur != prev) cnt = 0;
    else if (cur != NONE) cnt++;
    done = 1'b0;
    @(negedge sys_clk);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = '0;
    @(negedge sys_clk);
    do_reset("rst");

    // Single read after an I write
    req(0, 1'b1, 16'h20, 32'hAAAA); adv(); step(1'b1); adv(); step(1'b0);
    req(1, 1'b0, 16'h20, 32'h0); adv();
    chk("rd_stb", ram_stb_o, 1);
    step(1'b1);
    chk("rd_data", d_data_o, 32'hAAAA);
    chk("rd_iack", i_ack_o, 0);
    adv(); step(1'b0);

    // Contention from reset: D first, I next with no idle cycle
    do_reset("rst2");
    req(1, 1'b1, 16'h20, 32'h1111_2222);
    req(0, 1'b1, 16'h24, 32'h3333_4444);
    adv(); chk("ct_addr0", ram_addr_o, 16'h20); step(1'b1);
    adv(); chk("ct_addr1", ram_addr_o, 16'h24); step(1'b1);
    adv();

    // Sustained fairness: six transfers alternate D,I,D,I,D,I
    req(1, 1'b0, 16'h40, 32'h0); req(0, 1'b0, 16'h44, 32'h0); adv();
    for (int k = 0; k < 6; k++) begin
      chk("fair_addr", ram_addr_o, (k % 2 == 0) ? 16'h40 : 16'h44);
      step(1'b1);
      chk("fair_dack", d_ack_o, (k % 2 == 0));
      if (k < 4) req(last_m, 1'b0, (last_m == 1) ? 16'h40 : 16'h44, 32'h0);
      adv();
    end
    step(1'b0); adv();

    // Watchdog with nothing pending; TIMEOUT=0 instance holds its grant
    req(1, 1'b0, 16'h30, 32'h0); adv();
    for (int j = 0; j < 4; j++) begin
      step(1'b0);
      chk("wd0_stb", z_ram_stb_o, 1);
      chk("wd0_err", z_d_err_o, 0);
      adv();
    end
    for (int j = 0; j < 4; j++) begin
      step(1'b0);
      chk("wd_drop", ram_stb_o, 0);
      chk("wd0_hold", z_ram_stb_o, 1);
      chk("wd0_noerr", z_d_err_o, 0);
      adv();
    end

    // Watchdog with an I request pending
    req(1, 1'b0, 16'h30, 32'h0); adv(); step(1'b0);
    req(0, 1'b0, 16'h34, 32'h0);
    adv(); step(1'b0); adv(); step(1'b0); adv(); step(1'b0);
    chk("wdp_err", d_err_o, 1);
    adv(); chk("wdp_next", ram_addr_o, 16'h34); step(1'b1); adv();

    // Ack beats expiry
    do_reset("rst3");
    req(1, 1'b1, 16'h38, 32'h5A5A); adv();
    for (int j = 0; j < 3; j++) begin step(1'b0); adv(); end
    step(1'b1);
    chk("abe_ack", d_ack_o, 1);
    chk("abe_err", d_err_o, 0);
    adv();

    // Reset mid-grant
    req(0, 1'b0, 16'h20, 32'h0); adv();
    chk("rmg_stb", ram_stb_o, 1);
    ram_ack_i = 1'b1; ram_data_i = 32'hDEAD;
    sys_rst_n = 1'b0;
    #1;
    chk_zero("rmg");
    do_reset("rmg2");
    req(1, 1'b0, 16'h20, 32'h0); req(0, 1'b0, 16'h24, 32'h0); adv();
    chk("rmg_dfirst", ram_addr_o, 16'h20);
    step(1'b1); adv(); step(1'b1); adv();

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 99) < 55);
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 99) < 40)
          req(m, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7) * 4), $urandom);
      end
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
